// File: rtl/buzzer_dma_bridge_if.sv
// Bus bundle for the buzzer DMA bridge: two address-only client read ports
// (score and beat) plus the AHB-Lite master read port toward system memory.
interface buzzer_dma_bridge_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] SBDMA_HADDR;
  logic [31:0]       SBDMA_HRDATA;
  logic              SBDMA_HREADY;
  logic [ADDR_W-1:0] BBDMA_HADDR;
  logic [31:0]       BBDMA_HRDATA;
  logic              BBDMA_HREADY;
  logic [ADDR_W-1:0] M_HADDR;
  logic [1:0]        M_HTRANS;
  logic              M_HWRITE;
  logic [2:0]        M_HSIZE;
  logic [31:0]       M_HRDATA;
  logic              M_HREADY;
  logic              M_HRESP;

  // Bridge side
  modport master (
    input  SBDMA_HADDR, BBDMA_HADDR, M_HRDATA, M_HREADY, M_HRESP,
    output SBDMA_HRDATA, SBDMA_HREADY, BBDMA_HRDATA, BBDMA_HREADY,
           M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE
  );

  // Clients and memory side
  modport slave (
    output SBDMA_HADDR, BBDMA_HADDR, M_HRDATA, M_HREADY, M_HRESP,
    input  SBDMA_HRDATA, SBDMA_HREADY, BBDMA_HRDATA, BBDMA_HREADY,
           M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE
  );
endinterface

// File: rtl/buzzer_dma_bridge.sv
// One-entry halfword cache per buzzer DMA client; misses are arbitrated
// round-robin and fetched as single halfword reads over AHB-Lite.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no fetch in flight; grant a missing client if any
// ST_ADDR | NONSEQ address phase for cur_addr, held through wait states
// ST_DATA | data phase; result lands in the granted client's entry
module buzzer_dma_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inv,
  output logic err,
  buzzer_dma_bridge_if.master bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] tag_s;
  logic [ADDR_W-1:0] tag_b;
  logic [15:0]       data_s;
  logic [15:0]       data_b;
  logic              val_s;
  logic              val_b;
  logic              hit_s;
  logic              hit_b;
  logic              miss_s;
  logic              miss_b;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] cur_addr_d;
  logic              cur_b;
  logic              last_b;
  logic              discard;
  logic              grant;
  logic              grant_b;
  logic              complete;
  logic              keep;
  logic [15:0]       fetch_data;
  logic [1:0]        htrans_q;
  logic [1:0]        htrans_d;

  assign hit_s  = val_s && (bus.SBDMA_HADDR == tag_s);
  assign hit_b  = val_b && (bus.BBDMA_HADDR == tag_b);
  assign miss_s = !hit_s;
  assign miss_b = !hit_b;

  assign bus.SBDMA_HREADY = hit_s;
  assign bus.BBDMA_HREADY = hit_b;
  assign bus.SBDMA_HRDATA = {16'h0000, data_s};
  assign bus.BBDMA_HRDATA = {16'h0000, data_b};

  assign bus.M_HADDR  = cur_addr;
  assign bus.M_HTRANS = htrans_q;
  assign bus.M_HWRITE = 1'b0;
  assign bus.M_HSIZE  = 3'b001;

  // An error response still fills the entry (with zero) so the client never stalls.
  assign fetch_data = bus.M_HRESP ? 16'h0000
                    : (cur_addr[1] ? bus.M_HRDATA[31:16] : bus.M_HRDATA[15:0]);
  assign keep = !(discard || inv);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr;
    htrans_d   = htrans_q;
    grant      = 1'b0;
    grant_b    = 1'b0;
    complete   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (miss_s || miss_b) begin
          grant      = 1'b1;
          // On a tie the client that was not served last wins.
          grant_b    = miss_b && (!miss_s || !last_b);
          cur_addr_d = grant_b ? bus.BBDMA_HADDR : bus.SBDMA_HADDR;
          htrans_d   = HTRANS_NONSEQ;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.M_HREADY) begin
          htrans_d = HTRANS_IDLE;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.M_HREADY) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        htrans_d = HTRANS_IDLE;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= '0;
      htrans_q <= HTRANS_IDLE;
      cur_b    <= 1'b0;
      last_b   <= 1'b1;
      discard  <= 1'b0;
      err      <= 1'b0;
    end else begin
      cur_addr <= cur_addr_d;
      htrans_q <= htrans_d;
      err      <= complete && bus.M_HRESP;
      if (grant) begin
        cur_b  <= grant_b;
        last_b <= grant_b;
      end
      // A fetch overtaken by an invalidate must not leave a valid entry.
      if (complete) begin
        discard <= 1'b0;
      end else if (inv && (state_q != ST_IDLE)) begin
        discard <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_s  <= '0;
      tag_b  <= '0;
      data_s <= 16'h0000;
      data_b <= 16'h0000;
      val_s  <= 1'b0;
      val_b  <= 1'b0;
    end else begin
      if (inv) begin
        val_s <= 1'b0;
        val_b <= 1'b0;
      end
      if (complete) begin
        if (cur_b) begin
          tag_b  <= cur_addr;
          data_b <= fetch_data;
          val_b  <= keep;
        end else begin
          tag_s  <= cur_addr;
          data_s <= fetch_data;
          val_s  <= keep;
        end
      end
    end
  end

endmodule
